// File: rtl/dds_synth_pkg.sv
// dds_synth_pkg: shared types and constants for the DDS voice synthesiser.
// Holds the sequencer state enum, LUT geometry, default scale and clamp helper.
package dds_synth_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PHASE,
    S_LOOKUP,
    S_SCALE,
    S_ACCUM,
    S_OUT
  } state_e;

  localparam int          LUT_IDX_W       = 8;
  localparam int          LUT_SAMPLE_W    = 16;
  localparam logic [31:0] DDS_SCALE_46875 = 32'd91626;
  localparam logic [15:0] LFSR_SEED       = 16'hACE1;

  function automatic logic signed [31:0] sat_clamp(
    input logic signed [31:0] x,
    input int                 w
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/dds_poly_synth_sine_lut.sv
// sine_lut: combinational full-cycle sine table, entries built at elaboration.
// Entry i = round((2^(SAMPLE_W-1)-1) * sin(2*pi*i/2^IDX_W)).
module sine_lut #(
  parameter int IDX_W    = 8,
  parameter int SAMPLE_W = 16
) (
  input  logic [IDX_W-1:0]           i_idx,
  output logic signed [SAMPLE_W-1:0] o_val
);

  localparam real PI  = 3.14159265358979323846;
  localparam real AMP = (2.0 ** (SAMPLE_W - 1)) - 1.0;

  logic signed [SAMPLE_W-1:0] tbl [2**IDX_W];

  for (genvar i = 0; i < 2**IDX_W; i++) begin : g_tbl
    localparam real S = AMP * $sin(2.0 * PI * i / (2.0 ** IDX_W));
    localparam int  V = (S >= 0.0) ? $rtoi(S + 0.5)
                                   : -$rtoi(0.5 - S);
    assign tbl[i] = V[SAMPLE_W-1:0];
  end

  assign o_val = tbl[i_idx];

endmodule

// File: rtl/dds_poly_synth.sv
// dds_poly_synth: time-multiplexed multi-voice DDS with linear envelopes.
// Define DDS_PHASE_DITHER_EN to add LFSR phase dither ahead of LUT indexing.
module dds_poly_synth
  import dds_synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 32,
  parameter int IDX_W      = LUT_IDX_W,
  parameter int SAMPLE_W   = LUT_SAMPLE_W,
  parameter int ENV_W      = 8,
  parameter int FREQ_W     = 16
) (
  input  logic                         iCLK,
  input  logic                         AUD_DACLRCK,
  input  logic                         i_sample_tick,
  input  logic [NUM_VOICES*FREQ_W-1:0] i_freq,
  input  logic [NUM_VOICES-1:0]        i_gate,
  input  logic [PHASE_W-1:0]           i_incr_scale,
  input  logic [ENV_W-1:0]             i_env_rate,
  output logic signed [SAMPLE_W-1:0]   o_sample,
  output logic                         o_valid,
  output logic                         o_busy,
  output logic                         o_overrun
);

  localparam int VW     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACC_W  = SAMPLE_W + $clog2(NUM_VOICES) + 1;
  localparam int FRAC_W = PHASE_W - IDX_W;
  localparam logic [VW-1:0]    LAST_V  = VW'(NUM_VOICES - 1);
  localparam logic [ENV_W-1:0] ENV_MAX = '1;

  state_e                     state_q, state_d;
  logic [VW-1:0]              v_q, v_d;
  logic [PHASE_W-1:0]         phase_q [NUM_VOICES];
  logic [PHASE_W-1:0]         phase_d [NUM_VOICES];
  logic [ENV_W-1:0]           env_q [NUM_VOICES];
  logic [ENV_W-1:0]           env_d [NUM_VOICES];
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [SAMPLE_W-1:0] tbl_q, tbl_d;
  logic signed [SAMPLE_W:0]   prod_q, prod_d;
  logic signed [SAMPLE_W-1:0] sample_q, sample_d;
  logic                       valid_q, valid_d;
  logic                       ovr_q, ovr_d;

  logic [FREQ_W-1:0]          cur_freq;
  logic                       cur_gate;
  logic [ENV_W-1:0]           cur_env;
  logic [ENV_W:0]             env_sum;
  logic [ENV_W-1:0]           env_new;
  logic [PHASE_W-1:0]         incr;
  logic [IDX_W-1:0]           lut_idx;
  logic signed [SAMPLE_W-1:0] lut_val;
  logic signed [SAMPLE_W+ENV_W:0] prod_full;

  assign cur_freq = i_freq[v_q*FREQ_W +: FREQ_W];
  assign cur_gate = i_gate[v_q];
  assign cur_env  = env_q[v_q];
  assign env_sum  = {1'b0, cur_env} + {1'b0, i_env_rate};
  assign incr     = PHASE_W'(cur_freq) * i_incr_scale;
  assign prod_full = tbl_q * $signed({1'b0, cur_env});

  always_comb begin
    env_new = '0;
    if (cur_gate)
      env_new = env_sum[ENV_W] ? ENV_MAX : env_sum[ENV_W-1:0];
    else if (cur_env > i_env_rate)
      env_new = cur_env - i_env_rate;
  end

`ifdef DDS_PHASE_DITHER_EN
  localparam logic [PHASE_W-1:0] FRAC_MASK = {{IDX_W{1'b0}}, {FRAC_W{1'b1}}};

  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign lfsr_d  = (state_q == S_PHASE) ? {lfsr_fb, lfsr_q[15:1]} : lfsr_q;
  // Dither only perturbs the LUT address; the stored phase stays exact.
  assign lut_idx = IDX_W'((phase_q[v_q] + (PHASE_W'(lfsr_q) & FRAC_MASK)) >> FRAC_W);

  always_ff @(posedge iCLK or negedge AUD_DACLRCK) begin
    if (!AUD_DACLRCK) lfsr_q <= LFSR_SEED;
    else              lfsr_q <= lfsr_d;
  end
`else
  assign lut_idx = phase_q[v_q][PHASE_W-1 -: IDX_W];
`endif

  sine_lut #(
    .IDX_W    (IDX_W),
    .SAMPLE_W (SAMPLE_W)
  ) u_lut (
    .i_idx (lut_idx),
    .o_val (lut_val)
  );

  always_comb begin
    state_d  = state_q;
    v_d      = v_q;
    phase_d  = phase_q;
    env_d    = env_q;
    acc_d    = acc_q;
    tbl_d    = tbl_q;
    prod_d   = prod_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    ovr_d    = ovr_q | (i_sample_tick && state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (i_sample_tick) begin
          state_d = S_PHASE;
          v_d     = '0;
          acc_d   = '0;
        end
      end
      S_PHASE: begin
        env_d[v_q] = env_new;
        // A fully released voice parks at phase 0 so the next note starts clean.
        if (!cur_gate && env_new == '0) phase_d[v_q] = '0;
        else                            phase_d[v_q] = phase_q[v_q] + incr;
        state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        tbl_d   = lut_val;
        state_d = S_SCALE;
      end
      S_SCALE: begin
        prod_d  = (SAMPLE_W+1)'(prod_full >>> ENV_W);
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        acc_d = acc_q + ACC_W'(prod_q);
        if (v_q == LAST_V) begin
          state_d = S_OUT;
        end else begin
          v_d     = v_q + 1'b1;
          state_d = S_PHASE;
        end
      end
      S_OUT: begin
        sample_d = SAMPLE_W'(sat_clamp(32'(acc_q), SAMPLE_W));
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge AUD_DACLRCK) begin
    if (!AUD_DACLRCK) begin
      state_q  <= S_IDLE;
      v_q      <= '0;
      acc_q    <= '0;
      tbl_q    <= '0;
      prod_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase_q[i] <= '0;
        env_q[i]   <= '0;
      end
    end else begin
      state_q  <= state_d;
      v_q      <= v_d;
      acc_q    <= acc_d;
      tbl_q    <= tbl_d;
      prod_q   <= prod_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
      phase_q  <= phase_d;
      env_q    <= env_d;
    end
  end

  assign o_sample  = sample_q;
  assign o_valid   = valid_q;
  assign o_busy    = (state_q != S_IDLE);
  assign o_overrun = ovr_q;

endmodule

// File: tb/tb_dds_poly_synth.sv
// tb_dds_poly_synth: randomized self-checking bench for dds_poly_synth.
// Frame results come from an arithmetic model of voices, envelopes and mixing.
module tb_dds_poly_synth;

  localparam int NV  = 4;
  localparam int PW  = 32;
  localparam int IW  = 8;
  localparam int SW  = 16;
  localparam int EW  = 8;
  localparam int FW  = 16;
  localparam int LAT = 4 * NV + 1;
  localparam longint TWO32 = longint'(1) << 32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               tick = 1'b0;
  logic [NV*FW-1:0]   freq = '0;
  logic [NV-1:0]      gate = '0;
  logic [PW-1:0]      scale = 32'd91626;
  logic [EW-1:0]      rate = '0;
  logic signed [SW-1:0] o_sample;
  logic               o_valid;
  logic               o_busy;
  logic               o_overrun;

  int checks = 0;
  int errors = 0;

  int          sin_tbl [256];
  longint      m_ph [NV];
  int          m_env [NV];
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  dds_poly_synth #(
    .NUM_VOICES (NV),
    .PHASE_W    (PW),
    .IDX_W      (IW),
    .SAMPLE_W   (SW),
    .ENV_W      (EW),
    .FREQ_W     (FW)
  ) dut (
    .iCLK          (clk),
    .AUD_DACLRCK   (rst_n),
    .i_sample_tick (tick),
    .i_freq        (freq),
    .i_gate        (gate),
    .i_incr_scale  (scale),
    .i_env_rate    (rate),
    .o_sample      (o_sample),
    .o_valid       (o_valid),
    .o_busy        (o_busy),
    .o_overrun     (o_overrun)
  );

  function automatic void build_sin();
    for (int i = 0; i < 256; i++)
      sin_tbl[i] = $rtoi($floor(32767.0 * $sin(2.0 * 3.14159265358979 * i / 256.0) + 0.5));
  endfunction

  function automatic void model_reset();
    for (int v = 0; v < NV; v++) begin
      m_ph[v]  = 0;
      m_env[v] = 0;
    end
    m_lfsr = 16'hACE1;
  endfunction

  function automatic int model_frame();
    longint acc;
    longint look;
    int f, r, idx, p;
    bit g;
    acc = 0;
    r = int'(rate);
    for (int v = 0; v < NV; v++) begin
      f = int'(freq[v*FW +: FW]);
      g = gate[v];
      if (g) m_env[v] = (m_env[v] + r > 255) ? 255 : m_env[v] + r;
      else   m_env[v] = (m_env[v] - r < 0) ? 0 : m_env[v] - r;
      if (!g && m_env[v] == 0) m_ph[v] = 0;
      else m_ph[v] = (m_ph[v] + longint'(f) * longint'(scale)) % TWO32;
      look = m_ph[v];
`ifdef DDS_PHASE_DITHER_EN
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      look = (look + longint'(m_lfsr)) % TWO32;
`endif
      idx = int'(look / 16777216);
      p = $rtoi($floor(real'(sin_tbl[idx] * m_env[v]) / 256.0));
      acc += p;
    end
    if (acc > 32767) return 32767;
    if (acc < -32768) return -32768;
    return int'(acc);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(output int lat, output int smp);
    lat = -1;
    smp = 0;
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (o_valid) begin
        lat = k;
        smp = int'(o_sample);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int vcount, lat, smp, exp;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (o_sample !== '0 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got s=%0d v=%b b=%b o=%b want 0 0 0 0",
               o_sample, o_valid, o_busy, o_overrun);
    end
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    gate = '1;
    rate = 8'd200;
    scale = 32'd91626;
    for (int v = 0; v < NV; v++) freq[v*FW +: FW] = 16'($urandom_range(100, 5000));
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL midframe_busy got %b want 1", o_busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_sample !== '0 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset got s=%0d v=%b b=%b o=%b want 0 0 0 0",
               o_sample, o_valid, o_busy, o_overrun);
    end
    vcount = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (o_valid) vcount++;
    end
    checks++;
    if (vcount !== 0) begin
      errors++;
      $display("FAIL midframe_no_valid got %0d pulses want 0", vcount);
    end
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    exp = model_frame();
    run_frame(lat, smp);
    checks++;
    if (lat !== LAT || smp !== exp) begin
      errors++;
      $display("FAIL after_reset_frame got lat=%0d s=%0d want lat=%0d s=%0d", lat, smp, LAT, exp);
    end
  endtask

  task automatic test_single();
    int lat, smp, exp;
    do_reset();
    freq = '0;
    freq[FW-1:0] = 16'd1000;
    gate = 4'b0001;
    rate = 8'd255;
    scale = 32'd91626;
    exp = model_frame();
    run_frame(lat, smp);
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL single_latency got %0d want %0d", lat, LAT);
    end
    checks++;
    if (smp !== exp || smp !== 3995) begin
      errors++;
      $display("FAIL single_sample got %0d want %0d (model %0d)", smp, 3995, exp);
    end
  endtask

  task automatic test_saturation();
    int lat, smp, exp;
    do_reset();
    scale = 32'd65536;
    for (int v = 0; v < NV; v++) freq[v*FW +: FW] = 16'd16384;
    gate = '1;
    rate = 8'd255;
    for (int t = 0; t < 3; t++) begin
      exp = model_frame();
      run_frame(lat, smp);
      checks++;
      if (smp !== exp) begin
        errors++;
        $display("FAIL sat_frame%0d got %0d want %0d", t, smp, exp);
      end
      checks++;
      if ((t == 0 && smp !== 32767) || (t == 2 && smp !== -32768) || (t == 1 && smp !== 0)) begin
        errors++;
        $display("FAIL sat_bound%0d got %0d want %0d", t, smp, (t == 0) ? 32767 : (t == 2) ? -32768 : 0);
      end
    end
  endtask

  task automatic test_release();
    int lat, smp, exp;
    gate = '0;
    rate = 8'd64;
    for (int t = 0; t < 4; t++) begin
      exp = model_frame();
      run_frame(lat, smp);
      checks++;
      if (smp !== exp) begin
        errors++;
        $display("FAIL release_tick%0d got %0d want %0d", t, smp, exp);
      end
    end
    checks++;
    if (smp !== 0) begin
      errors++;
      $display("FAIL release_silent got %0d want 0", smp);
    end
  endtask

  task automatic test_overrun();
    int vcount, smp, exp, lat;
    gate = '1;
    rate = 8'd30;
    scale = 32'd91626;
    for (int v = 0; v < NV; v++) freq[v*FW +: FW] = 16'($urandom_range(1, 8000));
    exp = model_frame();
    vcount = 0;
    smp = 0;
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (o_valid) begin
        vcount++;
        smp = int'(o_sample);
      end
    end
    checks++;
    if (vcount !== 1 || smp !== exp) begin
      errors++;
      $display("FAIL overrun_frame got %0d pulses s=%0d want 1 s=%0d", vcount, smp, exp);
    end
    checks++;
    if (o_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flag got %b want 1", o_overrun);
    end
    exp = model_frame();
    run_frame(lat, smp);
    checks++;
    if (o_overrun !== 1'b1 || smp !== exp) begin
      errors++;
      $display("FAIL overrun_sticky got o=%b s=%0d want 1 s=%0d", o_overrun, smp, exp);
    end
  endtask

  task automatic test_random();
    int lat, smp, exp;
    do_reset();
    for (int t = 0; t < 25; t++) begin
      scale = 32'($urandom_range(0, 200000));
      rate  = 8'($urandom_range(0, 255));
      gate  = NV'($urandom);
      for (int v = 0; v < NV; v++)
        freq[v*FW +: FW] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      exp = model_frame();
      run_frame(lat, smp);
      checks++;
      if (lat !== LAT || smp !== exp) begin
        errors++;
        $display("FAIL random_frame%0d got lat=%0d s=%0d want lat=%0d s=%0d", t, lat, smp, LAT, exp);
      end
    end
  endtask

  task automatic test_dither();
    int lat, smp, exp;
    do_reset();
    freq = '0;
    gate = '1;
    rate = 8'd255;
    scale = 32'd91626;
    for (int t = 0; t < 6; t++) begin
      exp = model_frame();
      run_frame(lat, smp);
      checks++;
      if (smp !== exp) begin
        errors++;
        $display("FAIL dither_frame%0d got %0d want %0d", t, smp, exp);
      end
`ifndef DDS_PHASE_DITHER_EN
      checks++;
      if (smp !== 0) begin
        errors++;
        $display("FAIL nodither_dc%0d got %0d want 0", t, smp);
      end
`endif
    end
  endtask

  initial begin
    build_sin();
    model_reset();
    test_reset();
    test_single();
    test_saturation();
    test_release();
    test_overrun();
    test_random();
    test_dither();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
